// File: rtl/joy_sega6_scanner_if.sv
// Pin-side and core-side signals of the Sega/Atari DB9 joystick scanner.
// The slave modport is the scanner; the master modport is whatever drives the pads and tick.
interface joy_sega6_scanner_if;
  logic        tick;
  logic [5:0]  joy1_pins_i;
  logic [5:0]  joy2_pins_i;
  logic        p7_o;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        six1_o;
  logic        six2_o;
  logic        frame_done_o;

  modport master (
    output tick, joy1_pins_i, joy2_pins_i,
    input  p7_o, joy1_o, joy2_o, six1_o, six2_o, frame_done_o
  );

  modport slave (
    input  tick, joy1_pins_i, joy2_pins_i,
    output p7_o, joy1_o, joy2_o, six1_o, six2_o, frame_done_o
  );
endinterface

// File: rtl/joy_sega6_scanner.sv
// Scans two DB9 ports through the shared select line and decodes Master System,
// Mega Drive 3-button and 6-button pads into active-low 12-bit button words.
module joy_sega6_scanner #(
  parameter int CYCLE_LEN   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_sys,
  input  logic               reset,
  joy_sega6_scanner_if.slave bus
);

  typedef struct packed {
    logic [11:0] word;
    logic        six;
  } shadow_t;

  localparam logic [7:0] LAST_STEP  = 8'(CYCLE_LEN - 1);
  localparam shadow_t    SHADOW_RST = '{word: 12'hFFF, six: 1'b0};

  logic [5:0]  sync1 [SYNC_STAGES];
  logic [5:0]  sync2 [SYNC_STAGES];
  logic [5:0]  pins1;
  logic [5:0]  pins2;
  logic [7:0]  step;
  shadow_t     sh1;
  shadow_t     sh2;
  shadow_t     sh1_nxt;
  shadow_t     sh2_nxt;
  logic        p7_q;
  logic [11:0] joy1_q;
  logic [11:0] joy2_q;
  logic        six1_q;
  logic        six2_q;
  logic        frame_done_q;

  // pin = {p9, p6, right, left, down, up}; word = {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  function automatic shadow_t decode(input logic [7:0] s, input logic [5:0] pin,
                                     input shadow_t cur);
    shadow_t n;
    n = cur;
    case (s)
      8'd2: begin
        n.word[5:0] = pin;
        n.six       = 1'b0;
      end
      8'd3: begin
        // Right and left both low while select is low only happens on a Mega Drive pad.
        if (pin[3:2] == 2'b00) n.word[7:6] = pin[5:4];
        else                   n.word[7:4] = {2'b11, pin[5:4]};
      end
      8'd5: if (pin[3:0] == 4'b0000) n.six = 1'b1;
      8'd6: n.word[11:8] = cur.six ? pin[3:0] : 4'hF;
      default: ;
    endcase
    return n;
  endfunction

  // NOTE: the synchroniser is a handful of flops, not a RAM, so presetting it on reset is cheap and keeps the first frame clean.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync1[i] <= '1;
        sync2[i] <= '1;
      end
    end else begin
      sync1[0] <= bus.joy1_pins_i;
      sync2[0] <= bus.joy2_pins_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync1[i] <= sync1[i-1];
        sync2[i] <= sync2[i-1];
      end
    end
  end

  assign pins1 = sync1[SYNC_STAGES-1];
  assign pins2 = sync2[SYNC_STAGES-1];

  // NOTE: every output of a combinational block gets a value on every path, otherwise synthesis infers a latch.
  always_comb begin
    sh1_nxt = decode(step, pins1, sh1);
    sh2_nxt = decode(step, pins2, sh2);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      step         <= 8'd0;
      p7_q         <= 1'b1;
      sh1          <= SHADOW_RST;
      sh2          <= SHADOW_RST;
      joy1_q       <= 12'hFFF;
      joy2_q       <= 12'hFFF;
      six1_q       <= 1'b0;
      six2_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.tick) begin
        step <= (step == LAST_STEP) ? 8'd0 : step + 8'd1;
        // Steps 0..6 alternate low/high; the idle tail keeps select high so a 6-button pad times out.
        p7_q <= (step < 8'd7) ? step[0] : 1'b1;
        sh1  <= sh1_nxt;
        sh2  <= sh2_nxt;
        if (step == 8'd6) begin
          joy1_q       <= sh1_nxt.word;
          joy2_q       <= sh2_nxt.word;
          six1_q       <= sh1_nxt.six;
          six2_q       <= sh2_nxt.six;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.p7_o         = p7_q;
  assign bus.joy1_o       = joy1_q;
  assign bus.joy2_o       = joy2_q;
  assign bus.six1_o       = six1_q;
  assign bus.six2_o       = six2_q;
  assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_joy_sega6_scanner.sv
// Bench for joy_sega6_scanner: pad models on both ports, a pad-level reference of
// what each frame must publish, and a per-cycle compare against the DUT.
module tb_joy_sega6_scanner;

  localparam int CYCLE_LEN = 8;

  typedef enum logic [1:0] {PAD_MS, PAD_MD3, PAD_MD6} pad_t;

  logic clk_sys = 1'b0;
  logic reset;
  joy_sega6_scanner_if bus();

  joy_sega6_scanner #(.CYCLE_LEN(CYCLE_LEN), .SYNC_STAGES(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pads: buttons held as the ideal active-low word {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  pad_t        pad1_t, pad2_t;
  logic [11:0] pad1_b, pad2_b;
  int          low_cnt = 0;
  int          hi_cnt  = 0;
  logic        p7_q    = 1'b1;

  // Pins a real pad presents for a given select level and count of select lows since timeout.
  function automatic logic [5:0] pad_pins(input pad_t t, input logic [11:0] b,
                                          input logic p7, input int n);
    case (t)
      PAD_MS:  return b[5:0];
      PAD_MD3: return p7 ? b[5:0] : {b[7:6], 2'b00, b[1:0]};
      default: begin
        if (p7)          return (n == 3) ? {b[5:4], b[11:8]} : b[5:0];
        else if (n == 3) return {b[7:6], 4'b0000};
        else if (n == 4) return {b[7:6], 4'b1111};
        else             return {b[7:6], 2'b00, b[1:0]};
      end
    endcase
  endfunction

  function automatic logic [11:0] ideal(input pad_t t, input logic [11:0] b);
    case (t)
      PAD_MS:  return {6'h3F, b[5:0]};
      PAD_MD3: return {4'hF, b[7:0]};
      default: return b;
    endcase
  endfunction

  assign bus.joy1_pins_i = pad_pins(pad1_t, pad1_b, bus.p7_o, low_cnt);
  assign bus.joy2_pins_i = pad_pins(pad2_t, pad2_b, bus.p7_o, low_cnt);

  // Pad-internal select counter with a long-high timeout, as a 6-button pad behaves.
  always @(negedge clk_sys) begin
    if (p7_q && !bus.p7_o) low_cnt <= (low_cnt >= 4) ? 1 : low_cnt + 1;
    if (bus.p7_o) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= 40) low_cnt <= 0;
    end else begin
      hi_cnt <= 0;
    end
    p7_q <= bus.p7_o;
  end

  // Reference: step position, select level and what each frame publishes per pad.
  int          m_step;
  logic        m_p7, m_fd, m_s1, m_s2;
  logic [11:0] m_j1, m_j2;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_step <= 0;
      m_p7   <= 1'b1;
      m_fd   <= 1'b0;
      m_j1   <= 12'hFFF;
      m_j2   <= 12'hFFF;
      m_s1   <= 1'b0;
      m_s2   <= 1'b0;
    end else begin
      m_fd <= 1'b0;
      if (bus.tick) begin
        m_step <= (m_step + 1) % CYCLE_LEN;
        m_p7   <= (m_step < 7) ? ((m_step % 2) == 1) : 1'b1;
        if (m_step == 6) begin
          m_fd <= 1'b1;
          m_j1 <= ideal(pad1_t, pad1_b);
          m_j2 <= ideal(pad2_t, pad2_b);
          m_s1 <= (pad1_t == PAD_MD6);
          m_s2 <= (pad2_t == PAD_MD6);
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk_sys) begin
    if (cmp_en) begin
      check("p7",         {31'd0, bus.p7_o},         {31'd0, m_p7});
      check("frame_done", {31'd0, bus.frame_done_o}, {31'd0, m_fd});
      check("joy1",       {20'd0, bus.joy1_o},       {20'd0, m_j1});
      check("joy2",       {20'd0, bus.joy2_o},       {20'd0, m_j2});
      check("six1",       {31'd0, bus.six1_o},       {31'd0, m_s1});
      check("six2",       {31'd0, bus.six2_o},       {31'd0, m_s2});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1: one tick cycle, then four quiet cycles so pads settle through the synchroniser.
  task automatic step_tick();
    bus.tick = 1'b1;
    @(posedge clk_sys); #1;
    bus.tick = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic run_frame();
    repeat (CYCLE_LEN) step_tick();
  endtask

  function automatic logic [11:0] rand_buttons();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3:2] == 2'b00) b[3] = 1'b1;  // right+left cannot both be pressed on a d-pad
    if (b[1:0] == 2'b00) b[1] = 1'b1;  // nor down+up
    return b;
  endfunction

  logic [7:0] p7_pat = 8'hAA;
  logic [7:0] fd_pat = 8'h40;

  initial begin
    reset    = 1'b1;
    bus.tick = 1'b1;
    pad1_t = PAD_MS; pad1_b = 12'hFFF;
    pad2_t = PAD_MS; pad2_b = 12'hFFF;
    @(posedge clk_sys); #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_p7",   {31'd0, bus.p7_o},         32'd1);
    check("rst_joy1", {20'd0, bus.joy1_o},       32'hFFF);
    check("rst_joy2", {20'd0, bus.joy2_o},       32'hFFF);
    check("rst_six",  {30'd0, bus.six1_o, bus.six2_o}, 32'd0);
    check("rst_fd",   {31'd0, bus.frame_done_o}, 32'd0);

    // Tick held high: one step per cycle, three full frames.
    reset = 1'b0;
    for (int k = 0; k < 3 * CYCLE_LEN; k++) begin
      @(posedge clk_sys); #1;
      check("hold_p7",   {31'd0, bus.p7_o},         {31'd0, p7_pat[k % 8]});
      check("hold_fd",   {31'd0, bus.frame_done_o}, {31'd0, fd_pat[k % 8]});
      check("hold_joy1", {20'd0, bus.joy1_o},       32'hFFF);
    end
    bus.tick = 1'b0;
    repeat (50) @(posedge clk_sys);
    #1;

    // Master System pad: up and button 1 pressed.
    pad1_t = PAD_MS; pad1_b = 12'hFEE;
    run_frame();
    check("ms_joy1", {20'd0, bus.joy1_o}, 32'hFEE);
    check("ms_six1", {31'd0, bus.six1_o}, 32'd0);

    // 3-button pad with A on port 1, 6-button pad with X on port 2.
    pad1_t = PAD_MD3; pad1_b = 12'hFBF;
    pad2_t = PAD_MD6; pad2_b = 12'hBFF;
    run_frame();
    check("md3_sa",   {30'd0, bus.joy1_o[7:6]},  32'd2);
    check("md3_ext",  {28'd0, bus.joy1_o[11:8]}, 32'hF);
    check("md3_six1", {31'd0, bus.six1_o},       32'd0);
    check("md6_six2", {31'd0, bus.six2_o},       32'd1);
    check("md6_ext",  {28'd0, bus.joy2_o[11:8]}, 32'hB);

    // Reset in place of the step-4 tick: partial frame is dropped.
    pad1_t = PAD_MS;  pad1_b = 12'hFEE;
    pad2_t = PAD_MD6; pad2_b = 12'h7FE;
    repeat (4) step_tick();
    reset = 1'b1; bus.tick = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0; bus.tick = 1'b0;
    check("mid_joy1", {20'd0, bus.joy1_o}, 32'hFFF);
    check("mid_joy2", {20'd0, bus.joy2_o}, 32'hFFF);
    check("mid_six2", {31'd0, bus.six2_o}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_sys); #1;
      check("mid_fd", {31'd0, bus.frame_done_o}, 32'd0);
    end
    repeat (60) @(posedge clk_sys);
    #1;
    run_frame();
    check("post_joy1", {20'd0, bus.joy1_o}, 32'hFEE);
    check("post_joy2", {20'd0, bus.joy2_o}, 32'h7FE);
    check("post_six2", {31'd0, bus.six2_o}, 32'd1);

    // Random pads on both ports, checked every cycle by the compare process.
    for (int f = 0; f < 30; f++) begin
      pad1_t = pad_t'($urandom_range(0, 2));
      pad2_t = pad_t'($urandom_range(0, 2));
      pad1_b = rand_buttons();
      pad2_b = rand_buttons();
      run_frame();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
